// File: rtl/minc_run_ctrl.sv
// Run/halt/step/breakpoint sequencer for the minc stack CPU core.
// Gates the free-running core through cpu_en, stops on one PC breakpoint, counts executed cycles.
module minc_run_ctrl #(
    parameter int PC_W         = 8,
    parameter int CYC_W        = 16,
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [PC_W-1:0]  cmd_arg,
    input  logic [PC_W-1:0]  pc_in,
    output logic             cpu_en,
    output logic             halted,
    output logic             bp_hit,
    output logic             step_done,
    output logic             bp_en,
    output logic [PC_W-1:0]  bp_addr,
    output logic [CYC_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_t;

    localparam state_t RESET_STATE = RUN_ON_RESET ? ST_RUNNING : ST_HALTED;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_HALT    = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_SET_BP  = 3'd4;
    localparam logic [2:0] OP_CLR_BP  = 3'd5;
    localparam logic [2:0] OP_CLR_CNT = 3'd6;

    localparam logic [CYC_W-1:0] CNT_MAX  = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] CNT_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CNT_ZERO = {CYC_W{1'b0}};

    state_t            state_q, state_d;
    logic              skip_q, skip_d;
    logic              bp_en_q, bp_en_d;
    logic [PC_W-1:0]   bp_addr_q, bp_addr_d;
    logic              bp_hit_q, bp_hit_d;
    logic              step_done_q, step_done_d;
    logic [CYC_W-1:0]  cnt_q, cnt_d;

    logic              stop_s;
    logic              cpu_en_s;
    logic              cmd_ready_s;
    logic              accept_s;
    logic [2:0]        cmd_sel_s;
    logic              cmd_owns_state_s;

    // Breakpoint compare, core enable and handshake readiness
    always_comb begin
        stop_s = bp_en_q && (pc_in == bp_addr_q) && !skip_q && (state_q == ST_RUNNING);
        if (nRESET) begin
            cpu_en_s    = 1'b0;
            cmd_ready_s = 1'b0;
        end else begin
            cmd_ready_s = (state_q != ST_STEPPING);
            case (state_q)
                ST_RUNNING:  cpu_en_s = !stop_s;
                ST_STEPPING: cpu_en_s = 1'b1;
                default:     cpu_en_s = 1'b0;
            endcase
        end
    end

    assign accept_s  = cmd_valid && cmd_ready_s;
    assign cmd_sel_s = accept_s ? cmd_op : OP_NOP;

    // Next-state: natural progression first, then an accepted command overrides
    always_comb begin
        state_d     = state_q;
        skip_d      = cpu_en_s ? 1'b0 : skip_q;
        bp_en_d     = bp_en_q;
        bp_addr_d   = bp_addr_q;
        bp_hit_d    = bp_hit_q;
        step_done_d = 1'b0;

        case (cmd_sel_s)
            OP_RUN, OP_HALT, OP_STEP: cmd_owns_state_s = 1'b1;
            default:                  cmd_owns_state_s = 1'b0;
        endcase

        if (cpu_en_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        // A state-changing command on the stop edge suppresses the breakpoint hit
        if (state_q == ST_STEPPING) begin
            state_d     = ST_HALTED;
            step_done_d = 1'b1;
        end else if (stop_s && !cmd_owns_state_s) begin
            state_d  = ST_HALTED;
            bp_hit_d = 1'b1;
        end else begin
            state_d = state_q;
        end

        case (cmd_sel_s)
            OP_RUN: begin
                if (state_q == ST_HALTED) begin
                    state_d  = ST_RUNNING;
                    bp_hit_d = 1'b0;
                    skip_d   = (pc_in == bp_addr_q);
                end else begin
                    skip_d = skip_d | stop_s;
                end
            end
            OP_HALT: state_d = ST_HALTED;
            OP_STEP: begin
                if (state_q == ST_HALTED) begin
                    state_d  = ST_STEPPING;
                    bp_hit_d = 1'b0;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            OP_SET_BP: begin
                bp_addr_d = cmd_arg;
                bp_en_d   = 1'b1;
            end
            OP_CLR_BP:  bp_en_d = 1'b0;
            OP_CLR_CNT: cnt_d   = CNT_ZERO;
            default: ;
        endcase
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge CLK or posedge nRESET) begin
        if (nRESET) begin
            state_q     <= RESET_STATE;
            skip_q      <= 1'b0;
            bp_en_q     <= 1'b0;
            bp_addr_q   <= {PC_W{1'b0}};
            bp_hit_q    <= 1'b0;
            step_done_q <= 1'b0;
            cnt_q       <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            bp_en_q     <= bp_en_d;
            bp_addr_q   <= bp_addr_d;
            bp_hit_q    <= bp_hit_d;
            step_done_q <= step_done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cpu_en    = cpu_en_s;
    assign cmd_ready = cmd_ready_s;
    assign halted    = (state_q == ST_HALTED);
    assign bp_hit    = bp_hit_q;
    assign step_done = step_done_q;
    assign bp_en     = bp_en_q;
    assign bp_addr   = bp_addr_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: doc/minc_run_ctrl.md
Name: minc_run_ctrl

Overview:
- Run/halt/step/breakpoint sequencer for the minc stack CPU core.
- Drives the core's clock enable (cpu_en) from a small command interface and watches the core's pc_out to stop on a single PC breakpoint.
- Keeps a saturating count of executed cycles.
- Sits between a debug/loader host (or bench) and the minc core; the core's CLK is free-running and all gating is via cpu_en.

Parameters:
- PC_W, 8, width of program counter and breakpoint address.
- CYC_W, 16, width of the executed-cycle counter.
- RUN_ON_RESET, 1, 1 = leave reset in RUNNING, 0 = leave reset in HALTED.

Ports:
- CLK  in  1  clock, rising edge.
- nRESET  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  host command strobe.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 reserved (treated as NOP).
- cmd_arg  in  PC_W  breakpoint address for SET_BP; ignored otherwise.
- pc_in  in  PC_W  core pc_out (address of the next instruction).
- cpu_en  out  1  core clock enable; the core executes one instruction per CLK with cpu_en=1.
- halted  out  1  1 when state is HALTED.
- bp_hit  out  1  sticky; set when a breakpoint stops execution.
- step_done  out  1  one-cycle pulse when a STEP completes.
- bp_en  out  1  breakpoint armed.
- bp_addr  out  PC_W  armed breakpoint address.
- cycle_cnt  out  CYC_W  number of cycles with cpu_en=1, saturating.

Behaviour:
- Reset (nRESET=1, async):
  - state = RUNNING if RUN_ON_RESET else HALTED.
  - bp_en=0, bp_addr=0, bp_hit=0, step_done=0, cycle_cnt=0, skip=0.
  - cpu_en follows the state rules below, so it is forced to 0 while nRESET=1.
  - Reset mid-step or mid-run aborts immediately; there is no residual step.
- States:
  - HALTED: cpu_en=0.
  - RUNNING: cpu_en=1 unless the breakpoint stop condition holds.
  - STEPPING: lasts exactly one cycle, cpu_en=1.
- Breakpoint stop condition:
  - Condition: bp_en && pc_in==bp_addr && !skip && state==RUNNING.
  - cpu_en is combinational from registered state and pc_in, so the instruction at bp_addr is NOT executed.
  - On the following edge: state becomes HALTED and bp_hit is set to 1.
- Handshake:
  - Command accepted on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready=0 while nRESET=1 or state==STEPPING; otherwise 1.
  - Effects appear the cycle after acceptance.
- Commands:
  - RUN from HALTED: state becomes RUNNING and bp_hit is cleared. If pc_in==bp_addr at acceptance, skip is set so the breakpoint instruction executes once. skip clears after the first cycle with cpu_en=1.
  - RUN while RUNNING: no-op.
  - HALT: state becomes HALTED.
  - STEP in HALTED: state becomes STEPPING and bp_hit is cleared. The next cycle has cpu_en=1 regardless of breakpoint. Then state returns to HALTED with step_done=1 for exactly one cycle.
  - STEP in RUNNING: treated as HALT.
  - SET_BP: bp_addr=cmd_arg, bp_en=1. Allowed in any accepting state. Compare uses the new value from the next cycle.
  - CLR_BP: bp_en=0; bp_addr is unchanged.
  - CLR_CNT: cycle_cnt=0. If cpu_en=1 in the same cycle, the result is 0, not 1.
- Simultaneous events: if a breakpoint stop and an accepted command fall on the same edge, the command wins. RUN leaves state RUNNING with skip set; HALT, STEP, SET_BP and CLR_BP are applied normally. bp_hit is set only when the stop actually changes state to HALTED.
- cycle_cnt: increments on each edge where cpu_en=1 and holds at 2^CYC_W-1; there is no wrap.

Test Plan:
- Reset behaviour: RUN_ON_RESET=1, hold nRESET=1 for 2 cycles then release -> cpu_en=0, cmd_ready=0 and cycle_cnt=0 during reset; cpu_en=1 on the first edge after release; cycle_cnt=10 after 10 edges.
- Breakpoint stop and resume: SET_BP arg=0x05, core counts PC 0,1,2… -> cpu_en drops while pc_in=0x05; halted=1 and bp_hit=1 next cycle; pc stays 0x05. Then RUN -> PC advances to 0x06 (skip), and bp_hit clears.
- Single step: from HALTED at pc=0x10, issue STEP -> cmd_ready=0 for 1 cycle, exactly one cpu_en pulse, pc=0x11, step_done pulses once, halted=1. STEP again at a pc equal to bp_addr -> still executes one instruction.
- Command/breakpoint collision: RUN accepted on the same edge the breakpoint condition holds -> state stays RUNNING and no bp_hit. HALT command while running -> cpu_en=0 from the next cycle, with cycle_cnt frozen.
- Counter saturation: CYC_W=4, run 20 cycles -> cycle_cnt=15 and held. CLR_CNT while running -> reads 0, then 1 the following cycle.
- Async reset mid-operation: assert nRESET between edges while STEPPING -> cpu_en=0 immediately, bp_en=0, no step_done pulse.
